// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall sequencing,
// redirect squash sequencing and saturating stall/flush statistics.
module pipe_hazard_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NFWD      = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs,
  input  logic [4:0]           id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic [4:0]           ex_rs,
  input  logic [4:0]           ex_rt,
  input  logic [4:0]           ex_rw,
  input  logic                 ex_regwr,
  input  logic                 ex_memread,
  input  logic [XLEN-1:0]      ex_busA,
  input  logic [XLEN-1:0]      ex_busB,
  input  logic [5*NFWD-1:0]    fwd_rw,
  input  logic [NFWD-1:0]      fwd_regwr,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic                 redirect,
  output logic [XLEN-1:0]      ex_alua,
  output logic [XLEN-1:0]      ex_alub,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 id_ex_bubble,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [2:0] LAT_RELOAD   = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYC);

  logic [1:0]       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hazard;

  // Forwarding: scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    ex_alua = ex_busA;
    ex_alub = ex_busB;
    for (int i = int'(NFWD) - 1; i >= 0; i--) begin
      if (fwd_regwr[i] && (fwd_rw[i*5 +: 5] == ex_rs) && (ex_rs != 5'd0))
        ex_alua = fwd_data[i*XLEN +: XLEN];
      if (fwd_regwr[i] && (fwd_rw[i*5 +: 5] == ex_rt) && (ex_rt != 5'd0))
        ex_alub = fwd_data[i*XLEN +: XLEN];
    end
  end

  assign hazard = ex_memread && ex_regwr && (ex_rw != 5'd0) &&
                  ((id_rs_used && (id_rs == ex_rw)) ||
                   (id_rt_used && (id_rt == ex_rw)));

  // Next-state and control decode; redirect overrides every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      cnt_d       = FLUSH_RELOAD;
      state_d     = (FLUSH_CYC != 0) ? S_FLUSH : S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (hazard) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = S_STALL;
              cnt_d   = LAT_RELOAD;
            end
          end
        end
        S_STALL: begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
          cnt_d        = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_RUN;
        end
        S_FLUSH: begin
          if_id_flush = 1'b1;
          cnt_d       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = S_RUN;
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
    if (rst) begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
    end
  end

  // Saturating statistics.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
- REQ-001: The block SHALL have one clock; reset is synchronous and active-high (ports clk and rst).
- REQ-002: Parameters SHALL be (name, default, meaning):
  - XLEN, 32, datapath width.
  - NFWD, 2, number of forwarding source stages; index 0 is youngest (Mem), NFWD-1 oldest (Wr).
  - LOAD_LAT, 1, load-use stall cycles (1..7).
  - FLUSH_CYC, 1, extra IF/ID squash cycles after a redirect (0..3).
  - CNT_W, 16, statistics counter width.
- REQ-003: Ports SHALL be (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, synchronous active-high reset.
  - id_rs / id_rt, in, 5, ID-stage source register numbers.
  - id_rs_used / id_rt_used, in, 1, ID instruction reads that source.
  - ex_rs / ex_rt, in, 5, EX-stage source register numbers.
  - ex_rw, in, 5, EX destination register.
  - ex_regwr, in, 1, EX instruction writes a register.
  - ex_memread, in, 1, EX instruction is a load.
  - ex_busA / ex_busB, in, XLEN, register-file operands held in ID/EX.
  - fwd_rw, in, 5*NFWD, destination register per source stage.
  - fwd_regwr, in, NFWD, write enable per source stage.
  - fwd_data, in, XLEN*NFWD, result value per source stage.
  - redirect, in, 1, taken branch or jump resolved this cycle.
  - ex_alua / ex_alub, out, XLEN, forwarded EX operands.
  - pc_stall, out, 1, hold PC.
  - if_id_stall, out, 1, hold IF/ID.
  - id_ex_bubble, out, 1, load a NOP into ID/EX.
  - if_id_flush, out, 1, squash IF/ID.
  - id_ex_flush, out, 1, squash ID/EX.
  - stall_cnt / flush_cnt, out, CNT_W, statistics counters.

Function
- REQ-004: Forwarding SHALL be combinational. ex_alua SHALL equal fwd_data slice i for the lowest i with fwd_regwr[i]=1, fwd_rw slice i = ex_rs and ex_rs != 0; otherwise ex_alua SHALL equal ex_busA.
- REQ-005: ex_alub SHALL follow the REQ-004 rule using ex_rt and ex_busB.
- REQ-006: A load-use hazard SHALL be detected when all of the following hold: ex_memread=1, ex_regwr=1, ex_rw != 0, and (id_rs_used and id_rs=ex_rw) or (id_rt_used and id_rt=ex_rw).
- REQ-007: The FSM SHALL have three states: RUN, STALL and FLUSH. The state and a 3-bit down-counter cnt SHALL be registered.
- REQ-008: In RUN with a hazard and no redirect, the block SHALL assert pc_stall, if_id_stall and id_ex_bubble in the same cycle. If LOAD_LAT>1, it SHALL go to STALL with cnt=LOAD_LAT-1; otherwise it SHALL stay in RUN.
- REQ-009: In STALL, the block SHALL assert pc_stall, if_id_stall and id_ex_bubble and decrement cnt each cycle. When cnt=1, it SHALL return to RUN. The hazard input SHALL be ignored while in STALL.
- REQ-010: Whenever redirect=1 (any state), the block SHALL assert if_id_flush and id_ex_flush in the same cycle, deassert all stall outputs and clear cnt. If FLUSH_CYC>0, it SHALL go to FLUSH with cnt=FLUSH_CYC; otherwise it SHALL go to RUN.
- REQ-011: Redirect SHALL take priority over a simultaneous hazard.
- REQ-012: In FLUSH, the block SHALL assert if_id_flush only and decrement cnt. When cnt=1, it SHALL return to RUN. A hazard SHALL be ignored while in FLUSH. A new redirect SHALL reload cnt=FLUSH_CYC.
- REQ-013: stall_cnt SHALL increment on every cycle in which pc_stall=1.
- REQ-014: flush_cnt SHALL increment on every cycle in which redirect=1.
- REQ-015: Both counters SHALL saturate at all-ones and SHALL not wrap.
- REQ-016: Outputs SHALL never assert if_id_stall and if_id_flush in the same cycle.

Reset
- REQ-017: On rst=1 at a clock edge, the block SHALL set state to RUN, cnt to 0, and stall_cnt and flush_cnt to 0.
- REQ-018: While rst=1, pc_stall, if_id_stall, id_ex_bubble, if_id_flush and id_ex_flush SHALL be 0.
- REQ-019: The forwarding outputs SHALL remain combinational during reset.
- REQ-020: Reset asserted during STALL or FLUSH SHALL abort the sequence; the first cycle after reset SHALL be RUN with no stall.

Verification
- REQ-021: Forward priority: fwd slices 0 and 1 both target r5 with data 0x11 and 0x22, ex_rs=5 -> ex_alua=0x11. Then deassert fwd_regwr[0] -> ex_alua=0x22.
- REQ-022: r0 guard: fwd_rw=0, fwd_regwr=1, ex_rt=0, ex_busB=0 -> ex_alub=0 regardless of fwd_data.
- REQ-023: Load-use with LOAD_LAT=3: ex_memread=1, ex_rw=8, id_rt=8, id_rt_used=1 -> pc_stall high for exactly 3 cycles and stall_cnt=3.
- REQ-024: Redirect mid-stall with LOAD_LAT=3 and FLUSH_CYC=2: redirect in the 2nd stall cycle -> stalls drop that cycle, if_id_flush is high for 3 cycles, id_ex_flush is high for 1 cycle, and flush_cnt=1.
- REQ-025: Saturation with CNT_W=4: hold a hazard for 20 cycles with LOAD_LAT=1 -> stall_cnt=15 and stays 15.
- REQ-026: Reset mid-FLUSH: rst for 1 cycle -> all control outputs are 0 and both counters are 0 the next cycle.
